// File: rtl/rrf_pkg.sv
// rtl/rrf_pkg.sv - shared defaults, derived widths and popcount helper for the RRF free-list manager
package rrf_pkg;
   localparam int NUM_RRF_DEF = 8;
   localparam int ALLOC_W_DEF = 2;
   localparam int REL_W_DEF   = 2;
   localparam int TAG_W_DEF   = $clog2(NUM_RRF_DEF);
   localparam int CNT_W_DEF   = $clog2(NUM_RRF_DEF + 1);

   // Widest vector popcount accepts; callers zero-extend with POP_W'(...)
   localparam int POP_W = 64;

   function automatic int unsigned popcount(input logic [POP_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_W; i++) begin
         n = n + 32'(v[i]);
      end
      return n;
   endfunction
endpackage

// File: rtl/rrf_prio_pick.sv
// rtl/rrf_prio_pick.sv - find-first-set over a vector, lowest index wins
module rrf_prio_pick #(
   parameter int N = 8,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  vec_i,
   output logic [IW-1:0] idx_o,
   output logic [N-1:0]  onehot_o,
   output logic          valid_o
);

   always_comb begin
      idx_o    = '0;
      onehot_o = '0;
      valid_o  = 1'b0;
      // Scan downwards so the last hit written is the lowest set bit
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o       = IW'(i);
            onehot_o    = '0;
            onehot_o[i] = 1'b1;
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rrf_free_list_alloc.sv
// rtl/rrf_free_list_alloc.sv - rename-register free list: multi-slot grant, commit release, flush restore
// Optional same-cycle reuse of released tags: RRF_BYPASS_EN
module rrf_free_list_alloc
   import rrf_pkg::*;
#(
   parameter int NUM_RRF = NUM_RRF_DEF,
   parameter int ALLOC_W = ALLOC_W_DEF,
   parameter int REL_W   = REL_W_DEF,
   localparam int TAG_W  = $clog2(NUM_RRF),
   localparam int CNT_W  = $clog2(NUM_RRF + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ALLOC_W-1:0]       alloc_req,
   output logic [ALLOC_W-1:0]       alloc_gnt,
   output logic [ALLOC_W*TAG_W-1:0] alloc_tag,
   output logic                     alloc_stall,
   input  logic [REL_W-1:0]         rel_vld,
   input  logic [REL_W*TAG_W-1:0]   rel_tag,
   input  logic                     flush,
   output logic [CNT_W-1:0]         free_cnt,
   output logic                     rrf_full,
   output logic                     err_dbl_free
);

   logic [NUM_RRF-1:0] free_map_q, free_map_d;
   logic [CNT_W-1:0]   free_cnt_q, free_cnt_d;
   logic               rrf_full_q, rrf_full_d;
   logic               err_q, err_d;

   logic [NUM_RRF-1:0] rel_mask;
   logic               rel_err;
   logic [NUM_RRF-1:0] avail;
   logic [NUM_RRF-1:0] gnt_mask;
   int unsigned        n_req;
   int unsigned        n_avail;
   int unsigned        rank;

   logic [NUM_RRF-1:0] pick_in  [ALLOC_W];
   logic [NUM_RRF-1:0] pick_oh  [ALLOC_W];
   logic [TAG_W-1:0]   pick_idx [ALLOC_W];
   logic [ALLOC_W-1:0] pick_vld;

   always_comb begin
      rel_mask = '0;
      rel_err  = 1'b0;
      for (int i = 0; i < REL_W; i++) begin
         if (rel_vld[i]) begin
            if (32'(rel_tag[i*TAG_W +: TAG_W]) >= NUM_RRF) begin
               rel_err = 1'b1;
            end else begin
               // Already free, or already returned by a lower release slot this cycle
               if (free_map_q[rel_tag[i*TAG_W +: TAG_W]] || rel_mask[rel_tag[i*TAG_W +: TAG_W]]) begin
                  rel_err = 1'b1;
               end
               rel_mask[rel_tag[i*TAG_W +: TAG_W]] = 1'b1;
            end
         end
      end
   end

`ifdef RRF_BYPASS_EN
   assign avail = free_map_q | rel_mask;
`else
   assign avail = free_map_q;
`endif

   // Each picker sees what the previous ones left behind, giving ascending tags
   for (genvar k = 0; k < ALLOC_W; k++) begin : g_pick
      if (k == 0) begin : g_first
         assign pick_in[k] = avail;
      end else begin : g_next
         assign pick_in[k] = pick_in[k-1] & ~pick_oh[k-1];
      end
      rrf_prio_pick #(
         .N(NUM_RRF)
      ) u_pick (
         .vec_i   (pick_in[k]),
         .idx_o   (pick_idx[k]),
         .onehot_o(pick_oh[k]),
         .valid_o (pick_vld[k])
      );
   end

   assign n_req       = popcount(POP_W'(alloc_req));
   assign n_avail     = popcount(POP_W'(avail));
   assign alloc_stall = (n_req > n_avail) & ~flush;

   always_comb begin
      alloc_gnt = '0;
      alloc_tag = '0;
      gnt_mask  = '0;
      rank      = 0;
      for (int s = 0; s < ALLOC_W; s++) begin
         if (alloc_req[s]) begin
            for (int k = 0; k < ALLOC_W; k++) begin
               if (rank == k && pick_vld[k] && !alloc_stall && !flush) begin
                  alloc_gnt[s]                 = 1'b1;
                  alloc_tag[s*TAG_W +: TAG_W] = pick_idx[k];
                  gnt_mask                     = gnt_mask | pick_oh[k];
               end
            end
            rank = rank + 1;
         end
      end
   end

   always_comb begin
      if (flush) begin
         free_map_d = '1;
      end else begin
`ifdef RRF_BYPASS_EN
         // Grant wins over a same-cycle release of the same tag
         free_map_d = (free_map_q | rel_mask) & ~gnt_mask;
`else
         free_map_d = (free_map_q & ~gnt_mask) | rel_mask;
`endif
      end
      free_cnt_d = CNT_W'(popcount(POP_W'(free_map_d)));
      rrf_full_d = free_cnt_d < CNT_W'(ALLOC_W);
      // A flush discards the releases, so their error check is discarded too
      err_d      = err_q | (rel_err & ~flush);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         free_map_q <= '1;
         free_cnt_q <= CNT_W'(NUM_RRF);
         rrf_full_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         free_map_q <= free_map_d;
         free_cnt_q <= free_cnt_d;
         rrf_full_q <= rrf_full_d;
         err_q      <= err_d;
      end
   end

   assign free_cnt     = free_cnt_q;
   assign rrf_full     = rrf_full_q;
   assign err_dbl_free = err_q;

endmodule

// File: tb/tb_rrf_free_list_alloc.sv
// tb/tb_rrf_free_list_alloc.sv - vector table plus scoreboarded registered state for rrf_free_list_alloc
module tb_rrf_free_list_alloc;

   logic       clk;
   logic       rst_n;
   logic [1:0] alloc_req;
   logic [1:0] alloc_gnt;
   logic [5:0] alloc_tag;
   logic       alloc_stall;
   logic [1:0] rel_vld;
   logic [5:0] rel_tag;
   logic       flush;
   logic [3:0] free_cnt;
   logic       rrf_full;
   logic       err_dbl_free;

   int checks   = 0;
   int failures = 0;

   rrf_free_list_alloc dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc_req   (alloc_req),
      .alloc_gnt   (alloc_gnt),
      .alloc_tag   (alloc_tag),
      .alloc_stall (alloc_stall),
      .rel_vld     (rel_vld),
      .rel_tag     (rel_tag),
      .flush       (flush),
      .free_cnt    (free_cnt),
      .rrf_full    (rrf_full),
      .err_dbl_free(err_dbl_free)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] req;
      logic [1:0] rel_vld;
      logic [5:0] rel_tag;
      logic       flush;
      logic [1:0] gnt;
      logic [5:0] tag;
      logic       stall;
      logic [3:0] cnt;
      logic       full;
      logic       err;
   } vec_t;

   typedef struct {
      int         id;
      logic [3:0] cnt;
      logic       full;
      logic       err;
   } exp_t;

   vec_t vt [16];
   exp_t sbq [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] req, input logic [1:0] rv, input logic [5:0] rt,
                        input logic fl);
      @(negedge clk);
      alloc_req = req;
      rel_vld   = rv;
      rel_tag   = rt;
      flush     = fl;
      #1;
   endtask

   task automatic check_comb(input int id, input logic [1:0] gnt, input logic [5:0] tag,
                             input logic stall);
      chk($sformatf("s%0d_gnt", id), 32'(alloc_gnt), 32'(gnt));
      chk($sformatf("s%0d_tag", id), 32'(alloc_tag), 32'(tag));
      chk($sformatf("s%0d_stall", id), 32'(alloc_stall), 32'(stall));
   endtask

   task automatic push_exp(input int id, input logic [3:0] cnt, input logic full, input logic err);
      exp_t e;
      e.id   = id;
      e.cnt  = cnt;
      e.full = full;
      e.err  = err;
      sbq.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty actual=0 expected=1");
      end else begin
         e = sbq.pop_front();
         chk($sformatf("s%0d_free_cnt", e.id), 32'(free_cnt), 32'(e.cnt));
         chk($sformatf("s%0d_rrf_full", e.id), 32'(rrf_full), 32'(e.full));
         chk($sformatf("s%0d_err", e.id), 32'(err_dbl_free), 32'(e.err));
      end
   endtask

   task automatic step(input int id, input logic [1:0] req, input logic [1:0] rv,
                       input logic [5:0] rt, input logic fl,
                       input logic [1:0] gnt, input logic [5:0] tag, input logic stall,
                       input logic [3:0] cnt, input logic full, input logic err);
      drive(req, rv, rt, fl);
      check_comb(id, gnt, tag, stall);
      push_exp(id, cnt, full, err);
      pop_check();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Tag pairs are written in octal: {slot1, slot0}
      //        req    rel    rtag  fl    gnt    tag   stl   cnt   full  err
      vt[0]  = '{2'b11, 2'b00, 6'o00, 1'b0, 2'b11, 6'o10, 1'b0, 4'd6, 1'b0, 1'b0};
      vt[1]  = '{2'b10, 2'b00, 6'o00, 1'b0, 2'b10, 6'o20, 1'b0, 4'd5, 1'b0, 1'b0};
      vt[2]  = '{2'b01, 2'b00, 6'o00, 1'b0, 2'b01, 6'o03, 1'b0, 4'd4, 1'b0, 1'b0};
      vt[3]  = '{2'b11, 2'b00, 6'o00, 1'b0, 2'b11, 6'o54, 1'b0, 4'd2, 1'b0, 1'b0};
      vt[4]  = '{2'b01, 2'b00, 6'o00, 1'b0, 2'b01, 6'o06, 1'b0, 4'd1, 1'b1, 1'b0};
      vt[5]  = '{2'b11, 2'b00, 6'o00, 1'b0, 2'b00, 6'o00, 1'b1, 4'd1, 1'b1, 1'b0};
      vt[6]  = '{2'b01, 2'b00, 6'o00, 1'b0, 2'b01, 6'o07, 1'b0, 4'd0, 1'b1, 1'b0};
      vt[7]  = '{2'b00, 2'b11, 6'o53, 1'b0, 2'b00, 6'o00, 1'b0, 4'd2, 1'b0, 1'b0};
      vt[8]  = '{2'b11, 2'b00, 6'o00, 1'b0, 2'b11, 6'o53, 1'b0, 4'd0, 1'b1, 1'b0};
      vt[9]  = '{2'b00, 2'b01, 6'o01, 1'b0, 2'b00, 6'o00, 1'b0, 4'd1, 1'b1, 1'b0};
      vt[10] = '{2'b10, 2'b00, 6'o00, 1'b0, 2'b10, 6'o10, 1'b0, 4'd0, 1'b1, 1'b0};
      vt[11] = '{2'b00, 2'b11, 6'o60, 1'b0, 2'b00, 6'o00, 1'b0, 4'd2, 1'b0, 1'b0};
      vt[12] = '{2'b11, 2'b11, 6'o42, 1'b1, 2'b00, 6'o00, 1'b0, 4'd8, 1'b0, 1'b0};
      vt[13] = '{2'b00, 2'b01, 6'o02, 1'b0, 2'b00, 6'o00, 1'b0, 4'd8, 1'b0, 1'b1};
      vt[14] = '{2'b11, 2'b00, 6'o00, 1'b0, 2'b11, 6'o10, 1'b0, 4'd6, 1'b0, 1'b1};
      vt[15] = '{2'b00, 2'b11, 6'o00, 1'b0, 2'b00, 6'o00, 1'b0, 4'd7, 1'b0, 1'b1};

      rst_n     = 1'b1;
      alloc_req = '0;
      rel_vld   = '0;
      rel_tag   = '0;
      flush     = 1'b0;
      #2 rst_n  = 1'b0;
      #1;
      chk("reset_free_cnt", 32'(free_cnt), 32'd8);
      chk("reset_rrf_full", 32'(rrf_full), 32'd0);
      chk("reset_err", 32'(err_dbl_free), 32'd0);
      chk("reset_gnt", 32'(alloc_gnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         step(i, vt[i].req, vt[i].rel_vld, vt[i].rel_tag, vt[i].flush,
              vt[i].gnt, vt[i].tag, vt[i].stall, vt[i].cnt, vt[i].full, vt[i].err);
      end

      // Asynchronous reset between edges with tags {0..4} allocated
      step(100, 2'b11, 2'b00, 6'o00, 1'b0, 2'b11, 6'o20, 1'b0, 4'd5, 1'b0, 1'b1);
      step(101, 2'b11, 2'b00, 6'o00, 1'b0, 2'b11, 6'o43, 1'b0, 4'd3, 1'b0, 1'b1);
      drive(2'b11, 2'b00, 6'o00, 1'b0);
      chk("pre_reset_tag", 32'(alloc_tag), 32'o65);
      #1 rst_n = 1'b0;
      #1;
      chk("async_free_cnt", 32'(free_cnt), 32'd8);
      chk("async_rrf_full", 32'(rrf_full), 32'd0);
      chk("async_err", 32'(err_dbl_free), 32'd0);
      check_comb(102, 2'b11, 6'o10, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      alloc_req = '0;
      step(103, 2'b00, 2'b00, 6'o00, 1'b0, 2'b00, 6'o00, 1'b0, 4'd8, 1'b0, 1'b0);

      // Drain the pool, then release tag 4 while requesting one slot
      step(110, 2'b11, 2'b00, 6'o00, 1'b0, 2'b11, 6'o10, 1'b0, 4'd6, 1'b0, 1'b0);
      step(111, 2'b11, 2'b00, 6'o00, 1'b0, 2'b11, 6'o32, 1'b0, 4'd4, 1'b0, 1'b0);
      step(112, 2'b11, 2'b00, 6'o00, 1'b0, 2'b11, 6'o54, 1'b0, 4'd2, 1'b0, 1'b0);
      step(113, 2'b11, 2'b00, 6'o00, 1'b0, 2'b11, 6'o76, 1'b0, 4'd0, 1'b1, 1'b0);
`ifdef RRF_BYPASS_EN
      step(114, 2'b01, 2'b01, 6'o04, 1'b0, 2'b01, 6'o04, 1'b0, 4'd0, 1'b1, 1'b0);
      step(115, 2'b01, 2'b00, 6'o00, 1'b0, 2'b00, 6'o00, 1'b1, 4'd0, 1'b1, 1'b0);
`else
      step(114, 2'b01, 2'b01, 6'o04, 1'b0, 2'b00, 6'o00, 1'b1, 4'd1, 1'b1, 1'b0);
      step(115, 2'b01, 2'b00, 6'o00, 1'b0, 2'b01, 6'o04, 1'b0, 4'd0, 1'b1, 1'b0);
`endif
      // Same allocated tag in both release slots: counted once, flagged
      step(116, 2'b00, 2'b11, 6'o44, 1'b0, 2'b00, 6'o00, 1'b0, 4'd1, 1'b1, 1'b1);
      step(117, 2'b00, 2'b00, 6'o00, 1'b0, 2'b00, 6'o00, 1'b0, 4'd1, 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
